// File: rtl/mod_counter_pkg.sv
// Shared helpers for the modulo counter: prescaler width sizing and
// the parameter legality rule used at elaboration.
package mod_counter_pkg;

  function automatic int clog2_min1(input int value);
    int bits;
    bits = $clog2(value);
    return (bits < 1) ? 1 : bits;
  endfunction

  // MODULO is compared as a 64-bit value so 2**WIDTH cannot overflow the check.
  function automatic bit params_legal(input int width, input longint modulo,
                                      input int prescale);
    return (width >= 1) && (width <= 62) && (modulo >= 2) &&
           (modulo <= (longint'(1) << width)) && (prescale >= 1);
  endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Input prescaler: emits a one-cycle step every PRESCALE enabled cycles.
module mod_counter_prescaler
  import mod_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic enable_i,
  input  logic restart_i,
  output logic step_o
);

  localparam int PRE_W = clog2_min1(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre;

  // Clear/load restart the prescale window so a step never follows them early.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pre <= '0;
    end else if (restart_i) begin
      pre <= '0;
    end else if (enable_i) begin
      if (pre == PRE_LAST) begin
        pre <= '0;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  assign step_o = enable_i & ~restart_i & (pre == PRE_LAST);

endmodule

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with prescaler, synchronous clear/load
// and a registered wrap pulse.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULO   = 2 ** WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             up_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  output logic [WIDTH-1:0] counter_value_o,
  output logic             wrap_o
);

  generate
    if (!params_legal(WIDTH, longint'(MODULO), PRESCALE)) begin : g_bad_params
      $error("mod_counter: illegal WIDTH/MODULO/PRESCALE combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULO - 1);

  logic             step;
  logic             restart;
  logic [WIDTH-1:0] load_clamped;

  assign restart      = clear_i | load_i;
  assign load_clamped = (load_value_i > MAX_COUNT) ? MAX_COUNT : load_value_i;

  mod_counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .enable_i  (enable_i),
    .restart_i (restart),
    .step_o    (step)
  );

  // Priority: clear, then load, then a step in the sampled direction.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      counter_value_o <= '0;
      wrap_o          <= 1'b0;
    end else if (clear_i) begin
      counter_value_o <= '0;
      wrap_o          <= 1'b0;
    end else if (load_i) begin
      counter_value_o <= load_clamped;
      wrap_o          <= 1'b0;
    end else if (step) begin
      if (up_i) begin
        if (counter_value_o == MAX_COUNT) begin
          counter_value_o <= '0;
          wrap_o          <= 1'b1;
        end else begin
          counter_value_o <= counter_value_o + 1'b1;
          wrap_o          <= 1'b0;
        end
      end else begin
        if (counter_value_o == '0) begin
          counter_value_o <= MAX_COUNT;
          wrap_o          <= 1'b1;
        end else begin
          counter_value_o <= counter_value_o - 1'b1;
          wrap_o          <= 1'b0;
        end
      end
    end else begin
      wrap_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter covering three parameterisations:
// decimal counter, decimal counter with prescale 3, and full 8-bit range.
module tb_mod_counter;

  logic clock;
  logic reset;

  logic       a_enable, a_up, a_clear, a_load;
  logic [3:0] a_load_value, a_count;
  logic       a_wrap;

  logic       b_enable, b_up, b_clear, b_load;
  logic [3:0] b_load_value, b_count;
  logic       b_wrap;

  logic       c_enable, c_up, c_clear, c_load;
  logic [7:0] c_load_value, c_count;
  logic       c_wrap;

  int checks_total;
  int checks_passed;

  mod_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) dut_a (
    .clock_i (clock), .reset_i (reset), .enable_i (a_enable), .up_i (a_up),
    .clear_i (a_clear), .load_i (a_load), .load_value_i (a_load_value),
    .counter_value_o (a_count), .wrap_o (a_wrap)
  );

  mod_counter #(.WIDTH(4), .MODULO(10), .PRESCALE(3)) dut_b (
    .clock_i (clock), .reset_i (reset), .enable_i (b_enable), .up_i (b_up),
    .clear_i (b_clear), .load_i (b_load), .load_value_i (b_load_value),
    .counter_value_o (b_count), .wrap_o (b_wrap)
  );

  mod_counter #(.WIDTH(8), .MODULO(256), .PRESCALE(1)) dut_c (
    .clock_i (clock), .reset_i (reset), .enable_i (c_enable), .up_i (c_up),
    .clear_i (c_clear), .load_i (c_load), .load_value_i (c_load_value),
    .counter_value_o (c_count), .wrap_o (c_wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset = 1'b1;
    {a_enable, a_up, a_clear, a_load} = '0;
    {b_enable, b_up, b_clear, b_load} = '0;
    {c_enable, c_up, c_clear, c_load} = '0;
    a_load_value = '0;
    b_load_value = '0;
    c_load_value = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    check_output("reset a_count", 32'(a_count), 0);
    check_output("reset a_wrap", 32'(a_wrap), 0);
    check_output("reset b_count", 32'(b_count), 0);
    check_output("reset c_count", 32'(c_count), 0);

    // Up-count through the decimal wrap.
    a_enable = 1'b1;
    a_up     = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_output("a up count", 32'(a_count), 32'(i));
      check_output("a up wrap low", 32'(a_wrap), 0);
    end
    tick();
    check_output("a up wrap count", 32'(a_count), 0);
    check_output("a up wrap pulse", 32'(a_wrap), 1);
    tick();
    check_output("a after wrap count", 32'(a_count), 1);
    check_output("a after wrap pulse", 32'(a_wrap), 0);

    // Clear, then down-count from 0 wraps to 9.
    a_enable = 1'b0;
    a_clear  = 1'b1;
    tick();
    check_output("a clear", 32'(a_count), 0);
    a_clear  = 1'b0;
    a_enable = 1'b1;
    a_up     = 1'b0;
    tick();
    check_output("a down wrap count", 32'(a_count), 9);
    check_output("a down wrap pulse", 32'(a_wrap), 1);
    tick();
    check_output("a down count 8", 32'(a_count), 8);
    check_output("a down wrap low", 32'(a_wrap), 0);
    tick();
    check_output("a down count 7", 32'(a_count), 7);

    // Loads: clamping, load beating a step, clear beating load, hold.
    a_enable     = 1'b0;
    a_load       = 1'b1;
    a_load_value = 4'd12;
    tick();
    check_output("a load clamp", 32'(a_count), 9);
    check_output("a load clamp wrap", 32'(a_wrap), 0);
    a_enable     = 1'b1;
    a_up         = 1'b1;
    a_load_value = 4'd3;
    tick();
    check_output("a load on step", 32'(a_count), 3);
    check_output("a load on step wrap", 32'(a_wrap), 0);
    a_clear      = 1'b1;
    a_load_value = 4'd5;
    tick();
    check_output("a clear over load", 32'(a_count), 0);
    a_clear  = 1'b0;
    a_load   = 1'b0;
    a_enable = 1'b0;
    repeat (2) tick();
    check_output("a hold disabled", 32'(a_count), 0);
    check_output("a hold wrap", 32'(a_wrap), 0);

    // Full 8-bit range wraps both ways.
    c_load       = 1'b1;
    c_load_value = 8'd254;
    tick();
    check_output("c load 254", 32'(c_count), 254);
    c_load   = 1'b0;
    c_enable = 1'b1;
    c_up     = 1'b1;
    tick();
    check_output("c count 255", 32'(c_count), 255);
    check_output("c no wrap at 255", 32'(c_wrap), 0);
    tick();
    check_output("c wrap count", 32'(c_count), 0);
    check_output("c wrap pulse", 32'(c_wrap), 1);
    tick();
    check_output("c count 1", 32'(c_count), 1);
    c_up = 1'b0;
    tick();
    check_output("c down to 0", 32'(c_count), 0);
    check_output("c down to 0 wrap", 32'(c_wrap), 0);
    tick();
    check_output("c down wrap count", 32'(c_count), 255);
    check_output("c down wrap pulse", 32'(c_wrap), 1);
    c_enable = 1'b0;

    // Prescale 3 with enable toggling: step on the third high cycle.
    b_up = 1'b1;
    b_enable = 1'b1; tick(); check_output("b toggle 1", 32'(b_count), 0);
    b_enable = 1'b0; tick(); check_output("b toggle 2", 32'(b_count), 0);
    b_enable = 1'b1; tick(); check_output("b toggle 3", 32'(b_count), 0);
    b_enable = 1'b0; tick(); check_output("b toggle 4", 32'(b_count), 0);
    b_enable = 1'b1; tick(); check_output("b toggle 5", 32'(b_count), 1);
    check_output("b toggle wrap", 32'(b_wrap), 0);
    tick(); check_output("b cont 1", 32'(b_count), 1);
    tick(); check_output("b cont 2", 32'(b_count), 1);
    tick(); check_output("b cont 3", 32'(b_count), 2);

    // Park at count 7 with two enabled cycles into the prescale window.
    b_load       = 1'b1;
    b_load_value = 4'd7;
    tick();
    check_output("b load 7", 32'(b_count), 7);
    b_load = 1'b0;
    repeat (2) tick();
    check_output("b parked at 7", 32'(b_count), 7);

    // Asynchronous reset clears outputs before any clock edge.
    #1 reset = 1'b1;
    #1;
    check_output("b async reset count", 32'(b_count), 0);
    check_output("b async reset wrap", 32'(b_wrap), 0);
    @(negedge clock);
    reset = 1'b0;
    tick(); check_output("b post reset 1", 32'(b_count), 0);
    tick(); check_output("b post reset 2", 32'(b_count), 0);
    tick(); check_output("b post reset 3", 32'(b_count), 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
